// File: rtl/lc3_op_sequencer.sv
// Multi-cycle sequencer for LC-3 operate instructions (ADD, AND, NOT).
// Drives reg_file read selects, captures operands, writes the result back and updates NZP.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | instr_ready high, waiting for instr_valid
// READ  | SR_1/SR_2 driven; operands captured at the closing edge
// EXEC  | result computed and loaded with the write-port outputs
// WRITE | LD_REG/done high; CC loaded at the closing edge
// ERR   | unsupported opcode retiring: done and illegal high
module lc3_op_sequencer #(
    parameter int         DATA_W   = 16,
    parameter logic [2:0] CC_RESET = 3'b010
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       IR,
    input  logic [DATA_W-1:0] SR1_IN,
    input  logic [DATA_W-1:0] SR2_IN,
    output logic [2:0]        SR_1,
    output logic [2:0]        SR_2,
    output logic [2:0]        DR,
    output logic              LD_REG,
    output logic [DATA_W-1:0] bus_out,
    output logic [2:0]        CC,
    output logic              done,
    output logic              illegal
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        EXEC  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              instr_ready_q, instr_ready_d;
    logic [3:0]        op_q, op_d;
    logic [2:0]        dst_q, dst_d;
    logic              imm_sel_q, imm_sel_d;
    logic [4:0]        imm5_q, imm5_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [2:0]        sr_1_q, sr_1_d;
    logic [2:0]        sr_2_q, sr_2_d;
    logic [2:0]        dr_q, dr_d;
    logic              ld_reg_q, ld_reg_d;
    logic [DATA_W-1:0] bus_out_q, bus_out_d;
    logic [2:0]        cc_q, cc_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;

    logic [DATA_W-1:0] b_sel;
    logic [DATA_W-1:0] alu_res;
    logic              op_legal;

    assign op_legal = (IR[15:12] == OP_ADD) || (IR[15:12] == OP_AND) ||
                      (IR[15:12] == OP_NOT);

    always_comb begin
        b_sel   = imm_sel_q ? {{(DATA_W-5){imm5_q[4]}}, imm5_q} : b_q;
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = a_q + b_sel;
            OP_AND:  alu_res = a_q & b_sel;
            OP_NOT:  alu_res = ~a_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        instr_ready_d = instr_ready_q;
        op_d          = op_q;
        dst_d         = dst_q;
        imm_sel_d     = imm_sel_q;
        imm5_d        = imm5_q;
        a_d           = a_q;
        b_d           = b_q;
        result_d      = result_q;
        sr_1_d        = sr_1_q;
        sr_2_d        = sr_2_q;
        dr_d          = dr_q;
        bus_out_d     = bus_out_q;
        cc_d          = cc_q;
        ld_reg_d      = 1'b0;
        done_d        = 1'b0;
        illegal_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    op_d          = IR[15:12];
                    dst_d         = IR[11:9];
                    imm_sel_d     = IR[5];
                    imm5_d        = IR[4:0];
                    instr_ready_d = 1'b0;
                    if (op_legal) begin
                        // Selects are registered here so they are valid throughout READ.
                        sr_1_d  = IR[8:6];
                        sr_2_d  = IR[2:0];
                        state_d = READ;
                    end else begin
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = ERR;
                    end
                end
            end
            READ: begin
                a_d     = SR1_IN;
                b_d     = SR2_IN;
                state_d = EXEC;
            end
            EXEC: begin
                result_d  = alu_res;
                bus_out_d = alu_res;
                dr_d      = dst_q;
                ld_reg_d  = 1'b1;
                done_d    = 1'b1;
                state_d   = WRITE;
            end
            WRITE: begin
                if (result_q[DATA_W-1])
                    cc_d = 3'b100;
                else if (result_q == '0)
                    cc_d = 3'b010;
                else
                    cc_d = 3'b001;
                instr_ready_d = 1'b1;
                state_d       = IDLE;
            end
            ERR: begin
                instr_ready_d = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                instr_ready_d = 1'b1;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= IDLE;
            instr_ready_q <= 1'b1;
            op_q          <= '0;
            dst_q         <= '0;
            imm_sel_q     <= 1'b0;
            imm5_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            result_q      <= '0;
            sr_1_q        <= '0;
            sr_2_q        <= '0;
            dr_q          <= '0;
            ld_reg_q      <= 1'b0;
            bus_out_q     <= '0;
            cc_q          <= CC_RESET;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_ready_q <= instr_ready_d;
            op_q          <= op_d;
            dst_q         <= dst_d;
            imm_sel_q     <= imm_sel_d;
            imm5_q        <= imm5_d;
            a_q           <= a_d;
            b_q           <= b_d;
            result_q      <= result_d;
            sr_1_q        <= sr_1_d;
            sr_2_q        <= sr_2_d;
            dr_q          <= dr_d;
            ld_reg_q      <= ld_reg_d;
            bus_out_q     <= bus_out_d;
            cc_q          <= cc_d;
            done_q        <= done_d;
            illegal_q     <= illegal_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign SR_1        = sr_1_q;
    assign SR_2        = sr_2_q;
    assign DR          = dr_q;
    assign LD_REG      = ld_reg_q;
    assign bus_out     = bus_out_q;
    assign CC          = cc_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_lc3_op_sequencer.sv
// Directed bench for lc3_op_sequencer with a small behavioural register file
// on the read/write ports; expected values are hand-computed per vector.
module tb_lc3_op_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] IR = 16'h0000;
    logic [15:0] SR1_IN, SR2_IN;
    logic [2:0]  SR_1, SR_2, DR;
    logic        LD_REG;
    logic [15:0] bus_out;
    logic [2:0]  CC;
    logic        done, illegal;

    logic [15:0] rf [8];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_addr = 3'd0;
    logic [15:0] pre_data = 16'h0000;

    int n_checks = 0;
    int n_fail   = 0;

    lc3_op_sequencer #(.DATA_W(16), .CC_RESET(3'b010)) dut (
        .Clk(Clk), .Reset(Reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .IR(IR), .SR1_IN(SR1_IN), .SR2_IN(SR2_IN), .SR_1(SR_1), .SR_2(SR_2), .DR(DR),
        .LD_REG(LD_REG), .bus_out(bus_out), .CC(CC), .done(done), .illegal(illegal)
    );

    always #5 Clk = ~Clk;

    assign SR1_IN = rf[SR_1];
    assign SR2_IN = rf[SR_2];

    always @(posedge Clk) begin
        if (LD_REG)
            rf[DR] <= bus_out;
        else if (pre_we)
            rf[pre_addr] <= pre_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge Clk);
        pre_we = 1'b0;
    endtask

    // Called at a negedge while the sequencer is idle; instr_valid is held through cycles 1-3
    // with a junk IR to show that nothing is sampled while busy.
    task automatic run_legal(input string tag, input logic [15:0] ir, input logic [15:0] exp_bus,
                             input logic [2:0] exp_cc);
        instr_valid = 1'b1;
        IR = ir;
        chk({tag, "_ready_c0"}, instr_ready, 1);
        @(negedge Clk);
        IR = 16'h0000;
        chk({tag, "_sr1"}, SR_1, ir[8:6]);
        chk({tag, "_sr2"}, SR_2, ir[2:0]);
        chk({tag, "_c1_busy"}, {instr_ready, LD_REG, done}, 3'b000);
        @(negedge Clk);
        chk({tag, "_c2_busy"}, {instr_ready, LD_REG, done}, 3'b000);
        @(negedge Clk);
        chk({tag, "_c3_ctl"}, {instr_ready, LD_REG, done, illegal}, 4'b0110);
        chk({tag, "_dr"}, DR, ir[11:9]);
        chk({tag, "_bus"}, bus_out, exp_bus);
        @(negedge Clk);
        chk({tag, "_c4_ready"}, {instr_ready, LD_REG, done}, 3'b100);
        chk({tag, "_cc"}, CC, exp_cc);
        chk({tag, "_rf_wr"}, rf[ir[11:9]], exp_bus);
        instr_valid = 1'b0;
    endtask

    task automatic run_illegal(input string tag, input logic [15:0] ir, input logic [2:0] exp_cc);
        instr_valid = 1'b1;
        IR = ir;
        chk({tag, "_ready_c0"}, instr_ready, 1);
        @(negedge Clk);
        instr_valid = 1'b0;
        chk({tag, "_c1"}, {instr_ready, LD_REG, done, illegal}, 4'b0011);
        @(negedge Clk);
        chk({tag, "_c2"}, {instr_ready, LD_REG, done, illegal}, 4'b1000);
        chk({tag, "_cc"}, CC, exp_cc);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        #12;
        chk("rst_outs", {SR_1, SR_2, DR, LD_REG, CC, done, illegal}, {3'd0, 3'd0, 3'd0, 1'b0, 3'b010, 1'b0, 1'b0});
        chk("rst_bus", bus_out, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_ready", instr_ready, 1);

        // 1: ADD R3,R1,R2 with 5 + 7
        preload(3'd1, 16'd5);
        preload(3'd2, 16'd7);
        run_legal("add_rr", 16'h1642, 16'd12, 3'b001);

        // 2: ADD R1,R1,#-1 from 0, then read R1 back through SR_1
        preload(3'd1, 16'h0000);
        run_legal("add_imm_neg", 16'h127F, 16'hFFFF, 3'b100);
        run_legal("add_readback", 16'h1460, 16'hFFFF, 3'b100);

        // 3: AND R4,R4,#0 then NOT R5,R6
        preload(3'd4, 16'h1234);
        run_legal("and_imm0", 16'h5920, 16'h0000, 3'b010);
        preload(3'd6, 16'h00FF);
        run_legal("not", 16'h9BBF, 16'hFF00, 3'b100);

        // 4: 0x7FFF + 1 wraps to 0x8000
        preload(3'd1, 16'h7FFF);
        preload(3'd2, 16'h0001);
        run_legal("add_wrap", 16'h1642, 16'h8000, 3'b100);

        // AND register mode and a destination aliasing both sources
        preload(3'd1, 16'h0F0F);
        preload(3'd2, 16'h3C3C);
        run_legal("and_rr", 16'h5642, 16'h0C0C, 3'b001);
        run_legal("add_alias", 16'h1241, 16'h1E1E, 3'b001);

        // 5: unsupported opcodes retire with illegal, CC untouched
        run_illegal("ill_br", 16'h0000, 3'b001);
        run_illegal("ill_trap", 16'hF025, 3'b001);
        run_legal("after_ill", 16'h1262, 16'h1E1E + 16'h0002, 3'b001);

        // 6: reset during EXEC aborts the write
        instr_valid = 1'b1;
        IR = 16'h1642;
        @(negedge Clk);
        instr_valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("abort_outs", {SR_1, SR_2, DR, LD_REG, CC, done, illegal}, {3'd0, 3'd0, 3'd0, 1'b0, 3'b010, 1'b0, 1'b0});
        chk("abort_bus", bus_out, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            chk("abort_idle", {instr_ready, LD_REG, done, CC}, {1'b1, 1'b0, 1'b0, 3'b010});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
